// File: rtl/sram_data_responder_pkg.sv
// Shared definitions for the SRAM data responder: FSM encoding, default window base,
// and state-classification helpers.
package sram_data_responder_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic logic is_phase(input state_t s);
        return (s == ST_RD_LO) || (s == ST_RD_HI) || (s == ST_WR_LO) || (s == ST_WR_HI);
    endfunction

    function automatic logic is_write_phase(input state_t s);
        return (s == ST_WR_LO) || (s == ST_WR_HI);
    endfunction

endpackage

// File: rtl/sram_data_responder_wait_counter.sv
// Per-phase wait counter: counts 0..WAIT_CYCLES-1 and flags the final cycle, both for
// the current cycle and (looking ahead) for the cycle after the next edge.
module sram_data_responder_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tc,
    output logic o_last_next
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;

    assign w_count_next = i_clear ? '0 : r_count + CW'(1);
    assign o_tc         = (r_count == LAST);
    assign o_last_next  = (w_count_next == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

endmodule

// File: rtl/sram_data_responder.sv
// MEM-stage data-memory responder: serves 32-bit loads/stores from a 16-bit SRAM as two
// half-word accesses, stalling the pipeline through ready while an access is in flight.
module sram_data_responder
    import sram_data_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int WW = SRAM_AW - 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [WW-1:0]      r_word;
    logic [31:0]        r_wdata;
    logic [31:0]        w_offset;
    logic [WW-1:0]      w_word_sel;
    logic [31:0]        w_wdata_sel;
    logic               w_tc;
    logic               w_last_next;
    logic               w_cnt_clear;
    logic               w_unused_bits;
    logic [SRAM_AW-1:0] w_addr_next;
    logic [15:0]        w_dq_next;
    logic               w_oe_next;
    logic               w_we_n_next;

    assign w_offset      = address - BASE_ADDR;
    assign w_unused_bits = ^{w_offset[31:SRAM_AW+1], w_offset[1:0]};
    assign ready         = ~(rd_en | wr_en) | (r_state == ST_DONE);
    assign w_cnt_clear   = ~is_phase(r_state) | w_tc;

    sram_data_responder_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_cnt_clear),
        .o_tc        (w_tc),
        .o_last_next (w_last_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (wr_en) begin
                    w_state_next = ST_WR_LO;
                end else if (rd_en) begin
                    w_state_next = ST_RD_LO;
                end
            end
            ST_RD_LO: if (w_tc) w_state_next = ST_RD_HI;
            ST_RD_HI: if (w_tc) w_state_next = ST_DONE;
            ST_WR_LO: if (w_tc) w_state_next = ST_WR_HI;
            ST_WR_HI: if (w_tc) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // SRAM pins are registered, so they are decoded from the state about to be entered;
    // in IDLE the word index and store data come straight from the request.
    always_comb begin
        w_word_sel  = (r_state == ST_IDLE) ? w_offset[SRAM_AW:2] : r_word;
        w_wdata_sel = (r_state == ST_IDLE) ? write_data : r_wdata;
        w_addr_next = sram_addr;
        w_dq_next   = sram_dq_out;
        w_oe_next   = 1'b0;
        w_we_n_next = 1'b1;
        case (w_state_next)
            ST_RD_LO: w_addr_next = {w_word_sel, 1'b0};
            ST_RD_HI: w_addr_next = {w_word_sel, 1'b1};
            ST_WR_LO: begin
                w_addr_next = {w_word_sel, 1'b0};
                w_dq_next   = w_wdata_sel[15:0];
            end
            ST_WR_HI: begin
                w_addr_next = {w_word_sel, 1'b1};
                w_dq_next   = w_wdata_sel[31:16];
            end
            default: ;
        endcase
        if (is_write_phase(w_state_next)) begin
            w_oe_next   = 1'b1;
            w_we_n_next = w_last_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word      <= '0;
            r_wdata     <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            if ((r_state == ST_IDLE) && (w_state_next != ST_IDLE)) begin
                r_word  <= w_word_sel;
                r_wdata <= write_data;
            end
            if ((r_state == ST_RD_LO) && w_tc) begin
                read_data[15:0] <= sram_dq_in;
            end
            if ((r_state == ST_RD_HI) && w_tc) begin
                read_data[31:16] <= sram_dq_in;
            end
            sram_addr   <= w_addr_next;
            sram_dq_out <= w_dq_next;
            sram_dq_oe  <= w_oe_next;
            sram_we_n   <= w_we_n_next;
        end
    end

endmodule

// File: tb/tb_sram_data_responder.sv
// Self-checking bench: a WAIT_CYCLES=2 responder on a behavioural SRAM and a
// WAIT_CYCLES=1 responder on a pattern ROM, compared against a word-level model.
module tb_sram_data_responder;

    localparam int AW = 18;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          rd0, wr0, ready0, oe0, wen0;
    logic [31:0]   addr0, wdata0, rdata0;
    logic [AW-1:0] saddr0;
    logic [15:0]   dqo0, dqi0;

    logic          rd1, wr1, ready1, oe1, wen1;
    logic [31:0]   addr1, wdata1, rdata1;
    logic [AW-1:0] saddr1;
    logic [15:0]   dqo1, dqi1;

    sram_data_responder #(.BASE_ADDR(32'd1024), .SRAM_AW(AW), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .rd_en(rd0), .wr_en(wr0), .address(addr0),
        .write_data(wdata0), .read_data(rdata0), .ready(ready0), .sram_addr(saddr0),
        .sram_dq_out(dqo0), .sram_dq_in(dqi0), .sram_dq_oe(oe0), .sram_we_n(wen0)
    );

    sram_data_responder #(.BASE_ADDR(32'd1024), .SRAM_AW(AW), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(addr1),
        .write_data(wdata1), .read_data(rdata1), .ready(ready1), .sram_addr(saddr1),
        .sram_dq_out(dqo1), .sram_dq_in(dqi1), .sram_dq_oe(oe1), .sram_we_n(wen1)
    );

    // SRAM behind dut0: address/data sampled while we_n is low, committed when it rises.
    logic [15:0]   mem0 [0:(1<<AW)-1];
    logic [AW-1:0] pend_addr;
    logic [15:0]   pend_data;
    logic          pend_vld = 1'b0;
    assign dqi0 = mem0[saddr0];
    always @(negedge clk) begin
        if (wen0 === 1'b0) begin
            pend_addr <= saddr0;
            pend_data <= dqo0;
            pend_vld  <= 1'b1;
        end else if (pend_vld) begin
            mem0[pend_addr] <= pend_data;
            pend_vld        <= 1'b0;
        end
    end

    // Read-only pattern memory behind dut1.
    assign dqi1 = 16'(saddr1 * 18'd2654 + 18'd12345);

    function automatic logic [15:0] pat(input int h);
        return 16'(h * 2654 + 12345);
    endfunction

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] ref_words [int];
    int          written_q [$];
    logic [31:0] exp_rdata0;

    // Presents one request and counts stalled cycles until ready; returns in the
    // DONE cycle with the request still asserted.
    task automatic access(input bit sel, input bit wr, input bit rd, input int k,
                          input logic [31:0] data, output int stall);
        bit got;
        if (sel) begin
            wr1 = wr; rd1 = rd; addr1 = 32'(1024 + 4 * k); wdata1 = data;
        end else begin
            wr0 = wr; rd0 = rd; addr0 = 32'(1024 + 4 * k); wdata0 = data;
        end
        stall = 0;
        got   = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            #1;
            if (!wr && !sel) begin
                n_cmp++;
                if ({oe0, wen0} !== 2'b01) begin
                    n_err++;
                    $display("FAIL read_pins_quiet: got oe/we_n=%b expected 01", {oe0, wen0});
                end
            end
            if ((sel ? ready1 : ready0) === 1'b1) got = 1'b1;
            else begin
                stall++;
                @(negedge clk);
            end
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL ready_timeout: got no ready after 40 cycles expected ready");
        end
    endtask

    task automatic drop_req(input bit sel);
        @(negedge clk);
        if (sel) begin rd1 = 1'b0; wr1 = 1'b0; end
        else begin rd0 = 1'b0; wr0 = 1'b0; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({rdata0, dqo0, saddr0, oe0, wen0, ready0} !== {32'd0, 16'd0, 18'd0, 1'b0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got rd=%h dq=%h a=%h oe=%b we_n=%b rdy=%b expected 0 0 0 0 1 1",
                     rdata0, dqo0, saddr0, oe0, wen0, ready0);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); wr0 = 1'b1; addr0 = 32'(1024 + 400); wdata0 = $urandom;
        @(negedge clk); #1;
        n_cmp++;
        if (wen0 !== 1'b0) begin
            n_err++;
            $display("FAIL wr_lo_strobe: got we_n=%b expected 0", wen0);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; wr0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if ({wen0, oe0, ready0} !== 3'b101) begin
                n_err++;
                $display("FAIL reset_abort: cycle %0d got we_n/oe/rdy=%b expected 101", i, {wen0, oe0, ready0});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_write_read();
        int st;
        access(0, 1, 0, 0, 32'hDEADBEEF, st);
        n_cmp++;
        if (st != 5 || mem0[0] !== 16'hBEEF || mem0[1] !== 16'hDEAD) begin
            n_err++;
            $display("FAIL write_word0: got stall=%0d sram0=%h sram1=%h expected 5 BEEF DEAD", st, mem0[0], mem0[1]);
        end
        ref_words[0] = 32'hDEADBEEF; written_q.push_back(0);
        drop_req(0);
        @(negedge clk);
        access(0, 0, 1, 0, 32'h0, st);
        exp_rdata0 = 32'hDEADBEEF;
        n_cmp++;
        if (st != 5 || rdata0 !== exp_rdata0) begin
            n_err++;
            $display("FAIL read_word0: got stall=%0d data=%h expected 5 %h", st, rdata0, exp_rdata0);
        end
        drop_req(0);
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (rdata0 !== exp_rdata0 || ready0 !== 1'b1) begin
            n_err++;
            $display("FAIL read_hold: got data=%h rdy=%b expected %h 1", rdata0, ready0, exp_rdata0);
        end
    endtask

    task automatic test_write_wins();
        int st;
        @(negedge clk);
        access(0, 1, 1, 1, 32'h12345678, st);
        n_cmp++;
        if (st != 5 || mem0[2] !== 16'h5678 || mem0[3] !== 16'h1234 || rdata0 !== exp_rdata0) begin
            n_err++;
            $display("FAIL write_wins: got stall=%0d sram2=%h sram3=%h rd=%h expected 5 5678 1234 %h",
                     st, mem0[2], mem0[3], rdata0, exp_rdata0);
        end
        ref_words[1] = 32'h12345678; written_q.push_back(1);
        drop_req(0);
    endtask

    task automatic test_back_to_back();
        int st;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            access(0, 0, 1, i, 32'h0, st);
            exp_rdata0 = ref_words[i];
            n_cmp++;
            if (st != 5 || rdata0 !== exp_rdata0) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got stall=%0d data=%h expected 5 %h", i, st, rdata0, exp_rdata0);
            end
            @(negedge clk);
        end
        rd0 = 1'b0;
    endtask

    task automatic test_dropped_request();
        logic [31:0] d;
        d = $urandom;
        @(negedge clk); wr0 = 1'b1; addr0 = 32'(1024 + 4 * 5); wdata0 = d;
        repeat (2) @(negedge clk);
        wr0 = 1'b0;
        #1;
        n_cmp++;
        if (ready0 !== 1'b1) begin
            n_err++;
            $display("FAIL dropped_ready: got %b expected 1", ready0);
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if ({mem0[11], mem0[10]} !== d) begin
            n_err++;
            $display("FAIL dropped_write: got %h expected %h", {mem0[11], mem0[10]}, d);
        end
        ref_words[5] = d; written_q.push_back(5);
    endtask

    task automatic test_random();
        int st, op, k, gap;
        logic [31:0] d;
        for (int t = 0; t < 40; t++) begin
            op  = $urandom_range(0, 2);
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            if (op == 1) begin
                k = written_q[$urandom_range(0, written_q.size() - 1)];
                access(0, 0, 1, k, 32'h0, st);
                exp_rdata0 = ref_words[k];
                n_cmp++;
                if (st != 5 || rdata0 !== exp_rdata0) begin
                    n_err++;
                    $display("FAIL rand_read t=%0d k=%0d: got stall=%0d data=%h expected 5 %h", t, k, st, rdata0, exp_rdata0);
                end
            end else begin
                k = $urandom_range(0, 63);
                d = $urandom;
                access(0, 1, op == 2, k, d, st);
                n_cmp++;
                if (st != 5 || {mem0[2*k+1], mem0[2*k]} !== d || rdata0 !== exp_rdata0) begin
                    n_err++;
                    $display("FAIL rand_write t=%0d k=%0d: got stall=%0d word=%h rd=%h expected 5 %h %h",
                             t, k, st, {mem0[2*k+1], mem0[2*k]}, rdata0, d, exp_rdata0);
                end
                if (!ref_words.exists(k)) written_q.push_back(k);
                ref_words[k] = d;
            end
            $display("txn %0d op=%0d k=%0d stall=%0d", t, op, k, st);
            drop_req(0);
        end
    endtask

    task automatic test_wait1();
        int st, k;
        logic [31:0] exp1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({ready1, oe1, wen1} !== 3'b101) begin
                n_err++;
                $display("FAIL w1_quiet[%0d]: got rdy/oe/we_n=%b expected 101", i, {ready1, oe1, wen1});
            end
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            k = $urandom_range(0, 1000);
            access(1, 0, 1, k, 32'h0, st);
            exp1 = {pat(2 * k + 1), pat(2 * k)};
            n_cmp++;
            if (st != 3 || rdata1 !== exp1) begin
                n_err++;
                $display("FAIL w1_read[%0d] k=%0d: got stall=%0d data=%h expected 3 %h", i, k, st, rdata1, exp1);
            end
            if (i == 7) begin
                @(negedge clk);
                access(1, 1, 0, 3, 32'hCAFEF00D, st);
                n_cmp++;
                if (st != 3 || rdata1 !== exp1) begin
                    n_err++;
                    $display("FAIL w1_write: got stall=%0d rd=%h expected 3 %h", st, rdata1, exp1);
                end
            end
            @(negedge clk);
        end
        rd1 = 1'b0; wr1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
        exp_rdata0 = 32'd0;
        test_reset();
        test_write_read();
        test_write_wins();
        test_back_to_back();
        test_dropped_request();
        test_random();
        test_wait1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
